// File: rtl/sw_seq_loader.sv
// Serial-to-parallel base loader and start/done sequencer for the SW scoring core.
// One frame in flight: LOAD beats -> pulse start -> wait done -> hand off the score.
module sw_seq_loader #(
   parameter int unsigned Q_LEN        = 6,
   parameter int unsigned R_LEN        = 10,
   parameter int unsigned START_CYCLES = 12,
   parameter int unsigned SCORE_W      = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_in_valid,
   output logic                 io_in_ready,
   input  logic [1:0]           io_in_base,
   input  logic                 io_in_last,
   output logic [2*Q_LEN-1:0]   io_q_b,
   output logic [2*R_LEN-1:0]   io_r_b,
   output logic                 io_sw_start,
   input  logic                 io_sw_done,
   input  logic [SCORE_W-1:0]   io_sw_result,
   output logic                 io_out_valid,
   input  logic                 io_out_ready,
   output logic [SCORE_W-1:0]   io_out_score,
   output logic                 io_busy,
   output logic                 io_err
);

   localparam int unsigned N_BEATS = Q_LEN + R_LEN;
   localparam int unsigned CNT_W   = $clog2(N_BEATS);
   localparam int unsigned SCNT_W  = $clog2(START_CYCLES + 1);

   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N_BEATS - 1);
   localparam logic [SCNT_W-1:0] START_END = SCNT_W'(START_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_OUT
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   beat_cnt;
   logic [SCNT_W-1:0]  start_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         beat_cnt     <= '0;
         start_cnt    <= '0;
         io_q_b       <= '0;
         io_r_b       <= '0;
         io_sw_start  <= 1'b0;
         io_out_valid <= 1'b0;
         io_busy      <= 1'b0;
         io_err       <= 1'b0;
         io_out_score <= '0;
         io_in_ready  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               io_in_ready <= 1'b1;
               state       <= S_LOAD;
            end

            S_LOAD: begin
               if (io_in_valid && io_in_ready) begin
                  for (int unsigned i = 0; i < Q_LEN; i++)
                     if (beat_cnt == CNT_W'(i))
                        io_q_b[2*i +: 2] <= io_in_base;
                  for (int unsigned i = 0; i < R_LEN; i++)
                     if (beat_cnt == CNT_W'(Q_LEN + i))
                        io_r_b[2*i +: 2] <= io_in_base;

                  // Misframed beats still land in the vectors; the next frame overwrites them.
                  if (beat_cnt == LAST_IDX) begin
                     beat_cnt <= '0;
                     if (io_in_last) begin
                        io_in_ready <= 1'b0;
                        io_sw_start <= 1'b1;
                        io_busy     <= 1'b1;
                        start_cnt   <= '0;
                        state       <= S_START;
                     end else begin
                        io_err <= 1'b1;
                     end
                  end else if (io_in_last) begin
                     io_err   <= 1'b1;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end

            S_START: begin
               if (start_cnt == START_END) begin
                  io_sw_start <= 1'b0;
                  state       <= S_WAIT;
               end else begin
                  start_cnt <= start_cnt + 1'b1;
               end
            end

            S_WAIT: begin
               if (io_sw_done) begin
                  io_out_score <= io_sw_result;
                  io_out_valid <= 1'b1;
                  io_busy      <= 1'b0;
                  state        <= S_OUT;
               end
            end

            S_OUT: begin
               if (io_out_ready) begin
                  io_out_valid <= 1'b0;
                  io_in_ready  <= 1'b1;
                  state        <= S_LOAD;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sw_seq_loader.sv
// Directed bench for sw_seq_loader: framing, start window, done capture, output handshake, reset abort.
// Frames are packed words with base k at bits [2k+1:2k], query beats first.
module tb_sw_seq_loader;

   logic        clock;
   logic        reset;
   logic        io_in_valid;
   logic        io_in_ready;
   logic [1:0]  io_in_base;
   logic        io_in_last;
   logic [11:0] io_q_b;
   logic [19:0] io_r_b;
   logic        io_sw_start;
   logic        io_sw_done;
   logic [4:0]  io_sw_result;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [4:0]  io_out_score;
   logic        io_busy;
   logic        io_err;

   int tests = 0;
   int fails = 0;

   // q = 0,1,2,3,0,1 ; r = 0,3,2,0,1,2,3,1,3,0
   localparam logic [31:0] FRAME_A = {20'h3792C, 12'h4E4};
   localparam logic [31:0] FRAME_B = {20'hA5F01, 12'hC3B};

   sw_seq_loader #(
      .Q_LEN(6),
      .R_LEN(10),
      .START_CYCLES(12),
      .SCORE_W(5)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (io_in_valid),
      .io_in_ready  (io_in_ready),
      .io_in_base   (io_in_base),
      .io_in_last   (io_in_last),
      .io_q_b       (io_q_b),
      .io_r_b       (io_r_b),
      .io_sw_start  (io_sw_start),
      .io_sw_done   (io_sw_done),
      .io_sw_result (io_sw_result),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_score (io_out_score),
      .io_busy      (io_busy),
      .io_err       (io_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_beat(input logic [1:0] b, input logic l);
      bit ok;
      ok          = 1'b0;
      io_in_valid = 1'b1;
      io_in_base  = b;
      io_in_last  = l;
      for (int i = 0; i < 50; i++) begin
         if (io_in_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL beat_ready_timeout: io_in_ready=%b, required 1 within 50 cycles", io_in_ready);
      end
      tick();
      io_in_valid = 1'b0;
      io_in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] bases, input int n, input int last_at, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps)
            while ($urandom_range(0, 1) == 1) tick();
         drive_beat(bases[2*k +: 2], k == last_at);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      tests++;
      if ({io_in_ready, io_sw_start, io_out_valid, io_busy, io_err} !== 5'b0) begin
         fails++;
         $display("FAIL reset_flags: ready/start/valid/busy/err=%b, required 00000",
                  {io_in_ready, io_sw_start, io_out_valid, io_busy, io_err});
      end
      tests++;
      if (io_q_b !== 12'h0 || io_r_b !== 20'h0 || io_out_score !== 5'h0) begin
         fails++;
         $display("FAIL reset_data: q=%h r=%h score=%h, required all 0", io_q_b, io_r_b, io_out_score);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (io_in_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_at_release: got %b, required 0", io_in_ready);
      end
      tick();
      tests++;
      if (io_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_after_release: got %b, required 1", io_in_ready);
      end
   endtask

   task automatic test_basic_frame();
      int n;
      send_frame(FRAME_A, 16, 15, 1'b0);
      tests++;
      if (io_q_b !== 12'h4E4 || io_r_b !== 20'h3792C) begin
         fails++;
         $display("FAIL basic_vectors: q=%h r=%h, required q=4e4 r=3792c", io_q_b, io_r_b);
      end
      tests++;
      if (io_sw_start !== 1'b1 || io_busy !== 1'b1 || io_in_ready !== 1'b0) begin
         fails++;
         $display("FAIL basic_start_edge: start/busy/ready=%b%b%b, required 110",
                  io_sw_start, io_busy, io_in_ready);
      end
      n = 0;
      while (io_sw_start === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      tests++;
      if (n != 12) begin
         fails++;
         $display("FAIL basic_start_len: got %0d cycles, required 12", n);
      end
      tests++;
      if (io_err !== 1'b0 || io_busy !== 1'b1) begin
         fails++;
         $display("FAIL basic_wait_flags: err=%b busy=%b, required err=0 busy=1", io_err, io_busy);
      end
   endtask

   task automatic test_out_handshake();
      repeat (4) tick();
      tests++;
      if (io_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL valid_before_done: got %b, required 0", io_out_valid);
      end
      io_sw_done   = 1'b1;
      io_sw_result = 5'd7;
      tick();
      io_sw_done   = 1'b0;
      io_sw_result = 5'd0;
      tests++;
      if (io_out_valid !== 1'b1 || io_out_score !== 5'd7 || io_busy !== 1'b0) begin
         fails++;
         $display("FAIL done_capture: valid=%b score=%0d busy=%b, required valid=1 score=7 busy=0",
                  io_out_valid, io_out_score, io_busy);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (io_out_valid !== 1'b1 || io_out_score !== 5'd7) begin
            fails++;
            $display("FAIL out_hold[%0d]: valid=%b score=%0d, required valid=1 score=7",
                     i, io_out_valid, io_out_score);
         end
      end
      io_out_ready = 1'b1;
      tick();
      io_out_ready = 1'b0;
      tests++;
      if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL out_accept: valid=%b in_ready=%b, required valid=0 in_ready=1",
                  io_out_valid, io_in_ready);
      end
   endtask

   task automatic test_early_last();
      int n;
      int seen;
      send_frame(FRAME_A, 6, 5, 1'b0);
      tests++;
      if (io_err !== 1'b1 || io_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL early_last_err: err=%b in_ready=%b, required err=1 in_ready=1", io_err, io_in_ready);
      end
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         if (io_sw_start !== 1'b0 || io_busy !== 1'b0) seen++;
         tick();
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL early_last_no_start: start/busy high in %0d cycles, required 0", seen);
      end
      send_frame(FRAME_B, 16, 15, 1'b0);
      tests++;
      if (io_q_b !== 12'hC3B || io_r_b !== 20'hA5F01 || io_sw_start !== 1'b1) begin
         fails++;
         $display("FAIL recover_vectors: q=%h r=%h start=%b, required q=c3b r=a5f01 start=1",
                  io_q_b, io_r_b, io_sw_start);
      end
      n = 0;
      while (io_sw_start === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      tests++;
      if (n != 12) begin
         fails++;
         $display("FAIL recover_start_len: got %0d cycles, required 12", n);
      end
      io_sw_done   = 1'b1;
      io_sw_result = 5'd19;
      tick();
      io_sw_done   = 1'b0;
      tests++;
      if (io_out_valid !== 1'b1 || io_out_score !== 5'd19 || io_err !== 1'b1) begin
         fails++;
         $display("FAIL recover_result: valid=%b score=%0d err=%b, required valid=1 score=19 err=1",
                  io_out_valid, io_out_score, io_err);
      end
      io_out_ready = 1'b1;
      tick();
      io_out_ready = 1'b0;
   endtask

   task automatic test_gaps();
      int n;
      send_frame(FRAME_A, 16, 15, 1'b1);
      tests++;
      if (io_q_b !== 12'h4E4 || io_r_b !== 20'h3792C) begin
         fails++;
         $display("FAIL gaps_vectors: q=%h r=%h, required q=4e4 r=3792c", io_q_b, io_r_b);
      end
      tests++;
      if (io_sw_start !== 1'b1) begin
         fails++;
         $display("FAIL gaps_start_edge: got %b, required 1", io_sw_start);
      end
      n = 0;
      while (io_sw_start === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      tests++;
      if (n != 12) begin
         fails++;
         $display("FAIL gaps_start_len: got %0d cycles, required 12", n);
      end
      io_sw_done   = 1'b1;
      io_sw_result = 5'd11;
      tick();
      io_sw_done   = 1'b0;
      tests++;
      if (io_out_valid !== 1'b1 || io_out_score !== 5'd11) begin
         fails++;
         $display("FAIL gaps_result: valid=%b score=%0d, required valid=1 score=11", io_out_valid, io_out_score);
      end
      io_out_ready = 1'b1;
      tick();
      io_out_ready = 1'b0;
   endtask

   task automatic test_done_in_start();
      int n;
      int early;
      send_frame(FRAME_B, 16, 15, 1'b0);
      io_sw_done   = 1'b1;
      io_sw_result = 5'd3;
      n     = 0;
      early = 0;
      while (io_sw_start === 1'b1 && n < 40) begin
         if (io_out_valid !== 1'b0) early++;
         n++;
         tick();
      end
      tests++;
      if (n != 12 || early != 0) begin
         fails++;
         $display("FAIL done_in_start: start len %0d, valid seen %0d, required len 12 valid 0", n, early);
      end
      tests++;
      if (io_out_valid !== 1'b0 || io_busy !== 1'b1) begin
         fails++;
         $display("FAIL done_in_start_wait: valid=%b busy=%b, required valid=0 busy=1", io_out_valid, io_busy);
      end
      io_sw_result = 5'd22;
      tick();
      io_sw_done = 1'b0;
      tests++;
      if (io_out_valid !== 1'b1 || io_out_score !== 5'd22) begin
         fails++;
         $display("FAIL done_first_wait: valid=%b score=%0d, required valid=1 score=22", io_out_valid, io_out_score);
      end
      io_out_ready = 1'b1;
      tick();
      io_out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      int n;
      send_frame(FRAME_A, 16, 15, 1'b0);
      n = 0;
      while (io_sw_start === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      repeat (2) tick();
      tests++;
      if (io_busy !== 1'b1 || io_err !== 1'b1) begin
         fails++;
         $display("FAIL pre_abort: busy=%b err=%b, required busy=1 err=1", io_busy, io_err);
      end
      #3 reset = 1'b0;
      #1;
      tests++;
      if ({io_sw_start, io_busy, io_out_valid, io_err, io_in_ready} !== 5'b0 ||
          io_q_b !== 12'h0 || io_r_b !== 20'h0 || io_out_score !== 5'h0) begin
         fails++;
         $display("FAIL async_abort: start/busy/valid/err/ready=%b q=%h r=%h score=%h, required all 0",
                  {io_sw_start, io_busy, io_out_valid, io_err, io_in_ready}, io_q_b, io_r_b, io_out_score);
      end
      tick();
      reset = 1'b1;
      tick();
      send_frame(FRAME_B, 16, 15, 1'b0);
      tests++;
      if (io_q_b !== 12'hC3B || io_r_b !== 20'hA5F01 || io_sw_start !== 1'b1) begin
         fails++;
         $display("FAIL post_abort_vectors: q=%h r=%h start=%b, required q=c3b r=a5f01 start=1",
                  io_q_b, io_r_b, io_sw_start);
      end
      n = 0;
      while (io_sw_start === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      io_sw_done   = 1'b1;
      io_sw_result = 5'd5;
      tick();
      io_sw_done   = 1'b0;
      tests++;
      if (n != 12 || io_out_valid !== 1'b1 || io_out_score !== 5'd5 || io_err !== 1'b0) begin
         fails++;
         $display("FAIL post_abort_run: start len %0d valid=%b score=%0d err=%b, required 12 1 5 0",
                  n, io_out_valid, io_out_score, io_err);
      end
      io_out_ready = 1'b1;
      tick();
      io_out_ready = 1'b0;
   endtask

   initial begin
      reset        = 1'b0;
      io_in_valid  = 1'b0;
      io_in_base   = 2'd0;
      io_in_last   = 1'b0;
      io_sw_done   = 1'b0;
      io_sw_result = 5'd0;
      io_out_ready = 1'b0;
      test_reset();
      test_basic_frame();
      test_out_handshake();
      test_early_last();
      test_gaps();
      test_done_in_start();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required bench completion");
      $fatal(1, "watchdog");
   end

endmodule
